// File: rtl/kbd_matrix_ctrl.sv
// ---------------------------------------------------------------------------
// kbd_matrix_ctrl
//
// Single-clock owner of the PET keyboard matrix cache. The cache holds
// NUM_ROWS rows of 8 active-low key bits (0 = key down).
//   - The Pi bridge writes whole rows over a level req / pulse ack handshake.
//   - The CPU selects a row by writing PIA1 port A.
//   - The CPU reads port B and gets a registered snapshot of the selected row.
//   - A clear sweep releases every row, one row per clock.
//
// Optional feature (compile-time macro KBD_AUTO_RELEASE_EN):
//   When defined, an idle counter starts a clear sweep after RELEASE_TIMEOUT
//   clocks without an accepted Pi write. This releases stuck keys if the Pi
//   link dies. When undefined, no counter exists and the matrix holds
//   indefinitely.
//
// Ports:
//   clk           in   system clock
//   reset_n       in   asynchronous active-low reset
//   pi_wr_req     in   Pi write request (level, held until pi_wr_ack)
//   pi_wr_row     in   [3:0] target row, stable while pi_wr_req is high
//   pi_wr_data    in   [7:0] row data, stable while pi_wr_req is high
//   pi_wr_ack     out  one-cycle pulse, write accepted
//   clear_req     in   one-cycle pulse, start a clear sweep
//   cpu_row_wr    in   one-cycle pulse, CPU wrote PIA1 port A
//   cpu_row_data  in   [3:0] row select, sampled with cpu_row_wr
//   cpu_rd_req    in   level, CPU is reading PIA1 port B
//   kbd_data_out  out  [7:0] snapshot of the selected row
//   kbd_enable    out  intercept the port-B read
//   key_active    out  at least one row has a key down
//   busy          out  clear sweep in progress
// ---------------------------------------------------------------------------
module kbd_matrix_ctrl #(
  parameter int          NUM_ROWS        = 10,
  parameter logic [23:0] RELEASE_TIMEOUT = 24'd3_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pi_wr_req,
  input  logic [3:0] pi_wr_row,
  input  logic [7:0] pi_wr_data,
  output logic       pi_wr_ack,
  input  logic       clear_req,
  input  logic       cpu_row_wr,
  input  logic [3:0] cpu_row_data,
  input  logic       cpu_rd_req,
  output logic [7:0] kbd_data_out,
  output logic       kbd_enable,
  output logic       key_active,
  output logic       busy
);

  // Elaboration-time sanity check on the configuration.
  if (NUM_ROWS < 1 || NUM_ROWS > 16 || RELEASE_TIMEOUT == 24'd0) begin : g_param_check
    $error("kbd_matrix_ctrl: NUM_ROWS must be 1..16 and RELEASE_TIMEOUT nonzero");
  end

  localparam logic [4:0] NUM_ROWS_L = 5'(NUM_ROWS);
  localparam logic [3:0] LAST_IDX   = 4'(NUM_ROWS - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_e;

  state_e      state_q, state_d;

  // Storage is always 16 entries so any 4-bit row index is legal; entries at
  // or above NUM_ROWS are never written and stay 8'hFF (trimmed as constants).
  logic [7:0]  rows_q [16];
  logic [7:0]  rows_d [16];
  logic [15:0] pressed_q, pressed_d;

  logic [3:0]  cur_row_q, cur_row_d;
  logic [3:0]  idx_q, idx_d;
  logic        rd_req_prev_q;
  logic        rd_hit_q, rd_hit_d;
  logic        ack_q, ack_d;
  logic [7:0]  kbd_data_q, kbd_data_d;

  logic        rd_start;
  logic        pi_row_ok;
  logic        cpu_row_ok;
  logic [7:0]  snapshot;
  logic        timeout_hit;

`ifdef KBD_AUTO_RELEASE_EN
  logic [23:0] rel_cnt_q, rel_cnt_d;

  // Idle watchdog: any accepted Pi write or explicit clear restarts it; it
  // only advances while idle, so a running sweep never retriggers itself.
  always_comb begin
    rel_cnt_d   = rel_cnt_q;
    timeout_hit = 1'b0;
    if (ack_q || clear_req) begin
      rel_cnt_d = 24'd0;
    end else if (state_q == S_IDLE) begin
      if (rel_cnt_q == RELEASE_TIMEOUT - 24'd1) begin
        timeout_hit = 1'b1;
        rel_cnt_d   = 24'd0;
      end else begin
        rel_cnt_d = rel_cnt_q + 24'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rel_cnt_q <= 24'd0;
    end else begin
      rel_cnt_q <= rel_cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign rd_start   = cpu_rd_req & ~rd_req_prev_q;
  assign pi_row_ok  = ({1'b0, pi_wr_row} < NUM_ROWS_L);
  assign cpu_row_ok = ({1'b0, cur_row_q} < NUM_ROWS_L);

  // Next-state logic for the whole block.
  always_comb begin
    state_d    = state_q;
    rows_d     = rows_q;
    pressed_d  = pressed_q;
    cur_row_d  = cur_row_q;
    idx_d      = idx_q;
    rd_hit_d   = rd_hit_q;
    ack_d      = 1'b0;
    kbd_data_d = kbd_data_q;
    snapshot   = 8'hFF;

    // Row select is captured in every state, including during a sweep.
    if (cpu_row_wr) begin
      cur_row_d = cpu_row_data;
    end

    // The snapshot uses cur_row_q, so a same-edge row write does not affect
    // this read. A sweep in progress forces a released (all-ones) row.
    if (rd_start) begin
      if (state_q == S_IDLE && cpu_row_ok) begin
        snapshot = rows_q[cur_row_q];
      end
      kbd_data_d = snapshot;
      rd_hit_d   = (snapshot != 8'hFF);
    end else if (!cpu_rd_req) begin
      rd_hit_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        // A starting CPU read wins the cycle; the Pi write slips one clock.
        // Checking ack_q enforces at least one idle cycle between acks.
        if (pi_wr_req && !ack_q && !rd_start) begin
          ack_d = 1'b1;
          if (pi_row_ok) begin
            rows_d[pi_wr_row]    = pi_wr_data;
            pressed_d[pi_wr_row] = (pi_wr_data != 8'hFF);
          end
        end
        if (clear_req || timeout_hit) begin
          state_d = S_CLEAR;
          idx_d   = 4'd0;
        end
      end
      S_CLEAR: begin
        // One row per clock; clear_req is ignored here so a sweep never
        // restarts.
        rows_d[idx_q]    = 8'hFF;
        pressed_d[idx_q] = 1'b0;
        idx_d            = idx_q + 4'd1;
        if (idx_q == LAST_IDX) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      pressed_q     <= 16'd0;
      cur_row_q     <= 4'd0;
      idx_q         <= 4'd0;
      rd_req_prev_q <= 1'b0;
      rd_hit_q      <= 1'b0;
      ack_q         <= 1'b0;
      kbd_data_q    <= 8'hFF;
      for (int i = 0; i < 16; i++) begin
        rows_q[i] <= 8'hFF;
      end
    end else begin
      state_q       <= state_d;
      pressed_q     <= pressed_d;
      cur_row_q     <= cur_row_d;
      idx_q         <= idx_d;
      rd_req_prev_q <= cpu_rd_req;
      rd_hit_q      <= rd_hit_d;
      ack_q         <= ack_d;
      kbd_data_q    <= kbd_data_d;
      for (int i = 0; i < 16; i++) begin
        rows_q[i] <= rows_d[i];
      end
    end
  end

  assign pi_wr_ack    = ack_q;
  assign kbd_data_out = kbd_data_q;
  assign busy         = (state_q == S_CLEAR);
  // Enable falls combinationally with cpu_rd_req, without waiting a clock.
  assign kbd_enable   = cpu_rd_req & rd_hit_q & ~busy;
  assign key_active   = |pressed_q;

endmodule

// File: tb/tb_kbd_matrix_ctrl.sv
module tb_kbd_matrix_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pi_wr_req;
  logic [3:0] pi_wr_row;
  logic [7:0] pi_wr_data;
  logic       pi_wr_ack;
  logic       clear_req;
  logic       cpu_row_wr;
  logic [3:0] cpu_row_data;
  logic       cpu_rd_req;
  logic [7:0] kbd_data_out;
  logic       kbd_enable;
  logic       key_active;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  kbd_matrix_ctrl #(
    .NUM_ROWS       (10),
    .RELEASE_TIMEOUT(24'd16)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pi_wr_req   (pi_wr_req),
    .pi_wr_row   (pi_wr_row),
    .pi_wr_data  (pi_wr_data),
    .pi_wr_ack   (pi_wr_ack),
    .clear_req   (clear_req),
    .cpu_row_wr  (cpu_row_wr),
    .cpu_row_data(cpu_row_data),
    .cpu_rd_req  (cpu_rd_req),
    .kbd_data_out(kbd_data_out),
    .kbd_enable  (kbd_enable),
    .key_active  (key_active),
    .busy        (busy)
  );

  typedef struct {
    logic [3:0] row;
    logic [7:0] data;
    logic [7:0] exp_rd;
    logic       exp_en;
    logic       exp_ka;
  } vec_t;

  vec_t vecs [8];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Returns the number of clocks from raising pi_wr_req to seeing pi_wr_ack.
  task automatic pi_write(input logic [3:0] row, input logic [7:0] data, output int waited);
    pi_wr_req  = 1'b1;
    pi_wr_row  = row;
    pi_wr_data = data;
    waited     = 0;
    do begin
      step(1);
      waited++;
    end while (!pi_wr_ack && waited < 40);
    chk("pi_write_ack_seen", {31'd0, pi_wr_ack}, 32'd1);
    pi_wr_req = 1'b0;
  endtask

  task automatic cpu_select(input logic [3:0] row);
    cpu_row_wr   = 1'b1;
    cpu_row_data = row;
    step(1);
    cpu_row_wr = 1'b0;
  endtask

  task automatic cpu_read(input string tag, input logic [7:0] exp_d, input logic exp_en);
    cpu_rd_req = 1'b1;
    step(1);
    chk({tag, "_data"}, {24'd0, kbd_data_out}, {24'd0, exp_d});
    chk({tag, "_en"}, {31'd0, kbd_enable}, {31'd0, exp_en});
    step(3);
    chk({tag, "_data_hold"}, {24'd0, kbd_data_out}, {24'd0, exp_d});
    chk({tag, "_en_hold"}, {31'd0, kbd_enable}, {31'd0, exp_en});
    cpu_rd_req = 1'b0;
    #1;
    chk({tag, "_en_drop"}, {31'd0, kbd_enable}, 32'd0);
    step(1);
  endtask

  initial begin
    int waited;
    int acks;
    int busy_cnt;
    logic prev_ack;
    logic consec;

    vecs[0] = '{row: 4'd3,  data: 8'hFE, exp_rd: 8'hFE, exp_en: 1'b1, exp_ka: 1'b1};
    vecs[1] = '{row: 4'd3,  data: 8'hFF, exp_rd: 8'hFF, exp_en: 1'b0, exp_ka: 1'b0};
    vecs[2] = '{row: 4'd12, data: 8'h00, exp_rd: 8'hFF, exp_en: 1'b0, exp_ka: 1'b0};
    vecs[3] = '{row: 4'd0,  data: 8'h7F, exp_rd: 8'h7F, exp_en: 1'b1, exp_ka: 1'b1};
    vecs[4] = '{row: 4'd9,  data: 8'h7F, exp_rd: 8'h7F, exp_en: 1'b1, exp_ka: 1'b1};
    vecs[5] = '{row: 4'd15, data: 8'h00, exp_rd: 8'hFF, exp_en: 1'b0, exp_ka: 1'b1};
    vecs[6] = '{row: 4'd5,  data: 8'hA5, exp_rd: 8'hA5, exp_en: 1'b1, exp_ka: 1'b1};
    vecs[7] = '{row: 4'd0,  data: 8'hFF, exp_rd: 8'hFF, exp_en: 1'b0, exp_ka: 1'b1};

    reset_n      = 1'b0;
    pi_wr_req    = 1'b0;
    pi_wr_row    = 4'd0;
    pi_wr_data   = 8'hFF;
    clear_req    = 1'b0;
    cpu_row_wr   = 1'b0;
    cpu_row_data = 4'd0;
    cpu_rd_req   = 1'b0;
    step(3);

    // Reset state
    chk("rst_data", {24'd0, kbd_data_out}, 32'hFF);
    chk("rst_ack", {31'd0, pi_wr_ack}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ka", {31'd0, key_active}, 32'd0);
    chk("rst_en", {31'd0, kbd_enable}, 32'd0);
    reset_n = 1'b1;
    step(1);

    // Empty matrix read
    cpu_select(4'd3);
    cpu_read("empty_row3", 8'hFF, 1'b0);
    chk("empty_ka", {31'd0, key_active}, 32'd0);

    // Collision: read start and write request on the same edge
    pi_write(4'd3, 8'hFE, waited);
    chk("coll_setup_latency", waited, 32'd1);
    cpu_select(4'd3);
    cpu_rd_req = 1'b1;
    pi_wr_req  = 1'b1;
    pi_wr_row  = 4'd3;
    pi_wr_data = 8'hFF;
    step(1);
    chk("coll_old_data", {24'd0, kbd_data_out}, 32'hFE);
    chk("coll_ack_deferred", {31'd0, pi_wr_ack}, 32'd0);
    chk("coll_en", {31'd0, kbd_enable}, 32'd1);
    step(1);
    chk("coll_ack_late", {31'd0, pi_wr_ack}, 32'd1);
    pi_wr_req = 1'b0;
    step(1);
    chk("coll_ack_pulse", {31'd0, pi_wr_ack}, 32'd0);
    chk("coll_snapshot_held", {24'd0, kbd_data_out}, 32'hFE);
    chk("coll_ka", {31'd0, key_active}, 32'd0);
    cpu_rd_req = 1'b0;
    step(1);
    cpu_read("coll_reread", 8'hFF, 1'b0);

    // Table-driven write / select / read vectors
    for (int i = 0; i < 8; i++) begin
      pi_write(vecs[i].row, vecs[i].data, waited);
      chk($sformatf("vec%0d_ack_latency", i), waited, 32'd1);
      cpu_select(vecs[i].row);
      cpu_read($sformatf("vec%0d_read", i), vecs[i].exp_rd, vecs[i].exp_en);
      chk($sformatf("vec%0d_ka", i), {31'd0, key_active}, {31'd0, vecs[i].exp_ka});
    end

    // Held request: acks never on consecutive cycles
    acks       = 0;
    consec     = 1'b0;
    prev_ack   = 1'b0;
    pi_wr_req  = 1'b1;
    pi_wr_row  = 4'd12;
    pi_wr_data = 8'h00;
    for (int c = 0; c < 6; c++) begin
      step(1);
      if (pi_wr_ack) acks++;
      if (pi_wr_ack && prev_ack) consec = 1'b1;
      prev_ack = pi_wr_ack;
    end
    pi_wr_req = 1'b0;
    step(2);
    chk("held_req_acks", acks, 32'd3);
    chk("held_req_no_consec", {31'd0, consec}, 32'd0);

    // Clear sweep with stalled write, mid-sweep read, ignored clear_req
    pi_write(4'd0, 8'h7F, waited);
    pi_write(4'd9, 8'h7F, waited);
    cpu_select(4'd9);
    chk("sweep_pre_ka", {31'd0, key_active}, 32'd1);
    clear_req = 1'b1;
    step(1);
    clear_req  = 1'b0;
    pi_wr_req  = 1'b1;
    pi_wr_row  = 4'd2;
    pi_wr_data = 8'hFF;
    busy_cnt   = 0;
    acks       = 0;
    while (busy && busy_cnt < 30) begin
      busy_cnt++;
      if (pi_wr_ack) acks++;
      clear_req  = (busy_cnt == 3);
      cpu_row_wr = (busy_cnt == 6);
      cpu_row_data = 4'd4;
      if (busy_cnt == 2) cpu_rd_req = 1'b1;
      if (busy_cnt == 3) begin
        chk("sweep_read_data", {24'd0, kbd_data_out}, 32'hFF);
        chk("sweep_read_en", {31'd0, kbd_enable}, 32'd0);
      end
      if (busy_cnt == 5) cpu_rd_req = 1'b0;
      step(1);
    end
    clear_req  = 1'b0;
    cpu_row_wr = 1'b0;
    chk("sweep_busy_cycles", busy_cnt, 32'd10);
    chk("sweep_no_ack", acks, 32'd0);
    chk("sweep_ack_before_idle", {31'd0, pi_wr_ack}, 32'd0);
    step(1);
    chk("sweep_ack_after", {31'd0, pi_wr_ack}, 32'd1);
    pi_wr_req = 1'b0;
    step(1);
    chk("sweep_ka", {31'd0, key_active}, 32'd0);
    pi_write(4'd4, 8'h3C, waited);
    cpu_read("sweep_row_sel_captured", 8'h3C, 1'b1);
    pi_write(4'd4, 8'hFF, waited);
    cpu_select(4'd0);
    cpu_read("sweep_row0", 8'hFF, 1'b0);
    cpu_select(4'd9);
    cpu_read("sweep_row9", 8'hFF, 1'b0);

    // Reset asserted mid-sweep aborts it
    pi_write(4'd6, 8'h00, waited);
    clear_req = 1'b1;
    step(1);
    clear_req = 1'b0;
    step(2);
    chk("midsweep_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midsweep_rst_busy", {31'd0, busy}, 32'd0);
    chk("midsweep_rst_ka", {31'd0, key_active}, 32'd0);
    step(2);
    reset_n = 1'b1;
    step(1);
    chk("midsweep_after_busy", {31'd0, busy}, 32'd0);
    cpu_select(4'd5);
    cpu_read("midsweep_row5", 8'hFF, 1'b0);

    // Auto release
    pi_write(4'd1, 8'hEF, waited);
    cpu_select(4'd1);
`ifdef KBD_AUTO_RELEASE_EN
    busy_cnt = 0;
    while (!busy && busy_cnt < 40) begin
      busy_cnt++;
      step(1);
    end
    chk("autorel_sweep_started", {31'd0, busy}, 32'd1);
    busy_cnt = 0;
    while (busy && busy_cnt < 40) begin
      busy_cnt++;
      step(1);
    end
    chk("autorel_sweep_len", busy_cnt, 32'd10);
    cpu_read("autorel_row1", 8'hFF, 1'b0);
`else
    step(1000);
    chk("hold_busy", {31'd0, busy}, 32'd0);
    cpu_read("hold_row1", 8'hEF, 1'b1);
    chk("hold_ka", {31'd0, key_active}, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/kbd_matrix_ctrl.md
Name: kbd_matrix_ctrl

Overview:
Synchronous owner and arbiter of the PET keyboard matrix cache (NUM_ROWS x 8 bits, active-low key bits).
- Accepts row updates from the Pi bridge over a req/ack handshake.
- Tracks the CPU-selected row written via PIA1 port A.
- Serves CPU port-B reads with a registered snapshot.
- Runs a row-by-row clear sweep on request.
- Sits between the Pi register bridge and the PIA1 data-bus mux; replaces the edge-clocked matrix logic with single-clock logic.

Parameters:
NUM_ROWS, 10, number of matrix rows (1..16)
RELEASE_TIMEOUT, 24'd3_000_000, clk cycles without an accepted Pi write before auto-release (used only with the optional feature)

Ports:
clk  in  1  system clock; single clock domain
reset_n  in  1  asynchronous, active-low reset
pi_wr_req  in  1  level; Pi write request, held until pi_wr_ack
pi_wr_row  in  4  target row; stable while pi_wr_req is high
pi_wr_data  in  8  row data (0 = key down); stable while pi_wr_req is high
pi_wr_ack  out  1  one-cycle pulse; write accepted
clear_req  in  1  one-cycle pulse; start clear sweep
cpu_row_wr  in  1  one-cycle pulse; CPU wrote PIA1 port A
cpu_row_data  in  4  row select, sampled with cpu_row_wr
cpu_rd_req  in  1  level; CPU reading PIA1 port B (io_select & rw & pia1 & addr==2)
kbd_data_out  out  8  snapshot of the selected row
kbd_enable  out  1  intercept port-B read
key_active  out  1  any row has a key down
busy  out  1  clear sweep in progress

Behaviour:
- Reset (async, reset_n low):
  - All rows = 8'hFF; pressed_mask = 0; current_row = 0.
  - kbd_data_out = 8'hFF; pi_wr_ack = 0; rd_hit = 0; state = IDLE; busy = 0; release counter = 0.
  - Reset asserted mid-sweep or mid-handshake aborts it immediately; no ack is issued for a pending request.
- Row select: on a clk edge with cpu_row_wr = 1, current_row <= cpu_row_data.
- CPU read:
  - rd_start = cpu_rd_req & ~cpu_rd_req_d (registered previous value).
  - On the edge where rd_start = 1: kbd_data_out <= (current_row < NUM_ROWS) ? row[current_row] : 8'hFF, and rd_hit <= (that value != 8'hFF).
  - Latency: 1 clk from first sampled-high cpu_rd_req.
  - If cpu_row_wr and rd_start occur on the same edge, the read uses the old current_row.
  - kbd_enable = cpu_rd_req & rd_hit & ~busy. It drops combinationally when cpu_rd_req falls. rd_hit clears on the edge where cpu_rd_req is sampled low.
  - kbd_data_out holds its snapshot until the next rd_start; Pi writes during the read do not alter it.
- Pi write arbitration (state IDLE only):
  - Write is performed and pi_wr_ack pulses on an edge where pi_wr_req = 1, pi_wr_ack is currently 0, and rd_start = 0.
  - rd_start has priority; a colliding write is deferred exactly 1 clk.
  - pi_wr_row >= NUM_ROWS: acked, no storage change.
  - pressed_mask[row] <= (pi_wr_data != 8'hFF).
  - pi_wr_ack is never high on two consecutive cycles. A requester holding pi_wr_req high gets at most one ack per 2 clk.
- key_active = |pressed_mask (registered mask, combinational OR).
- Clear sweep:
  - clear_req in IDLE: state CLEAR, busy = 1, sweep index = 0.
  - Each clk: row[index] <= 8'hFF, pressed_mask[index] <= 0, index++.
  - After row NUM_ROWS-1 is written: state returns to IDLE, busy = 0. Total time is NUM_ROWS clk.
  - During CLEAR: no pi_wr_ack (requests stall); CPU reads return 8'hFF with kbd_enable = 0; cpu_row_wr is still captured.
  - clear_req while already in CLEAR is ignored; the sweep does not restart.

Optional Feature:
KBD_AUTO_RELEASE_EN
- Defined: a 24-bit counter increments each clk in IDLE and resets to 0 on every pi_wr_ack or clear_req. On reaching RELEASE_TIMEOUT-1, it starts a clear sweep and resets to 0. This releases stuck keys if the Pi link dies.
- Undefined: no counter is instantiated; the matrix holds indefinitely. RELEASE_TIMEOUT is unused.

Test Plan:
- Reset, then cpu_row_wr row 3 and cpu_rd_req high 4 clk -> kbd_data_out = 8'hFF, kbd_enable = 0, key_active = 0.
- Pi write row 3 = 8'hFE (ack 1 clk after req); select row 3; read -> kbd_data_out = 8'hFE 1 clk after cpu_rd_req rises, kbd_enable = 1 until cpu_rd_req falls, key_active = 1.
- pi_wr_req (row 3 = 8'hFF) rising on the same edge as rd_start on row 3 -> read returns old 8'hFE, ack 1 clk later, next read returns 8'hFF, key_active = 0.
- Pi write row 12 = 8'h00 with NUM_ROWS = 10 -> ack pulses, all rows unchanged; select row 12, read -> 8'hFF, kbd_enable = 0.
- Rows 0 and 9 = 8'h7F; clear_req; pi_wr_req asserted during sweep -> busy high exactly 10 clk, no ack until busy falls; reads after sweep return 8'hFF; key_active = 0.
- With KBD_AUTO_RELEASE_EN and RELEASE_TIMEOUT = 16: write row 1 = 8'hEF, idle 16 clk -> sweep starts, row 1 reads 8'hFF. Without the macro, row 1 still reads 8'hEF after 1000 clk.
